cook_sequencer: RTL and testbench

Central sequencer for the microwave: captures keypad digits into a three-digit BCD cook time (M:ST:SO), runs the per-second countdown and gates the magnetron. Sits between the raw front-panel inputs (keypad, startn, stopn, door_closed) and the seven-segment decoders and magnetron driver. Owns the state machine; decoders consume its BCD outputs directly.

---
 rtl/cook_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_cook_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: keypad entry of an M:ST:SO BCD cook time, per-second countdown, magnetron gating.
// Optional feature macro QUICK_START_EN: start in IDLE loads 0:30 and cooks; start while cooking adds a minute.
module cook_sequencer #(
  parameter int TICK_DIV = 100,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [9:0] keypad,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic [3:0] min_bcd,
  output logic [3:0] sec_tens_bcd,
  output logic [3:0] sec_ones_bcd,
  output logic       mag_on,
  output logic       cooking,
  output logic       done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, SET, COOK, PAUSE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    min_q, min_d, tens_q, tens_d, ones_q, ones_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [RW-1:0] run_q, run_d;
  logic [9:0]    key_q;
  logic          startn_q, stopn_q;
  logic          lock_q, lock_d;
  logic          done_q, done_d;
  logic          cooking_q, cooking_d;

  logic          start_press, stop_press;
  logic          key_valid, key_accept;
  logic          tick, last_sec, time_zero;
  logic [3:0]    key_digit, dec_min, dec_tens, dec_ones;

  // A press is the first cycle the button is seen low after being high.
  assign start_press = startn_q & ~startn;
  assign stop_press  = stopn_q & ~stopn;

  assign key_valid = $onehot(keypad);
  assign tick      = (pre_q == PW'(TICK_DIV - 1));
  assign last_sec  = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);
  assign time_zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);

  // Keypad debounce: run_d counts consecutive samples of one valid code;
  // lock holds off a second acceptance until the keypad reads all-zero.
  always_comb begin
    key_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (keypad[i]) key_digit = 4'(i);
    end
    if (!key_valid)                      run_d = '0;
    else if (keypad != key_q)            run_d = RW'(1);
    else if (run_q == RW'(DEBOUNCE))     run_d = run_q;
    else                                 run_d = run_q + 1'b1;
    key_accept = key_valid && (run_d == RW'(DEBOUNCE)) && !lock_q;
    if (keypad == 10'd0)   lock_d = 1'b0;
    else if (key_accept)   lock_d = 1'b1;
    else                   lock_d = lock_q;
  end

  // One-second decrement with BCD borrow; tens above 5 count straight down.
  always_comb begin
    dec_min  = min_q;
    dec_tens = tens_q;
    dec_ones = ones_q - 4'd1;
    if (ones_q == 4'd0) begin
      dec_ones = 4'd9;
      if (tens_q == 4'd0) begin
        dec_tens = 4'd5;
        dec_min  = min_q - 4'd1;
      end else begin
        dec_tens = tens_q - 4'd1;
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (stop_press) begin
          min_d = 4'd0; tens_d = 4'd0; ones_d = 4'd0;
`ifdef QUICK_START_EN
        end else if (start_press && door_closed) begin
          min_d = 4'd0; tens_d = 4'd3; ones_d = 4'd0;
          pre_d   = '0;
          state_d = COOK;
`endif
        end else if (key_accept) begin
          min_d = tens_q; tens_d = ones_q; ones_d = key_digit;
          state_d = SET;
        end
      end
      SET: begin
        if (stop_press) begin
          min_d = 4'd0; tens_d = 4'd0; ones_d = 4'd0;
          state_d = IDLE;
        end else if (start_press && door_closed && !time_zero) begin
          pre_d   = '0;
          state_d = COOK;
        end else if (key_accept) begin
          min_d = tens_q; tens_d = ones_q; ones_d = key_digit;
        end
      end
      COOK: begin
        if (tick && last_sec) begin
          min_d = 4'd0; tens_d = 4'd0; ones_d = 4'd0;
          pre_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (!door_closed || stop_press) begin
          state_d = PAUSE;
        end else begin
          if (tick) begin
            pre_d = '0;
            min_d = dec_min; tens_d = dec_tens; ones_d = dec_ones;
          end else begin
            pre_d = pre_q + 1'b1;
          end
`ifdef QUICK_START_EN
          if (start_press) min_d = (min_d == 4'd9) ? 4'd9 : min_d + 4'd1;
`endif
        end
      end
      PAUSE: begin
        if (stop_press) begin
          min_d = 4'd0; tens_d = 4'd0; ones_d = 4'd0;
          state_d = IDLE;
        end else if (start_press && door_closed) begin
          state_d = COOK;
        end
      end
      default: state_d = IDLE;
    endcase
    cooking_d = (state_d == COOK) || (state_d == PAUSE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      min_q     <= 4'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      pre_q     <= '0;
      run_q     <= '0;
      key_q     <= 10'd0;
      startn_q  <= 1'b1;
      stopn_q   <= 1'b1;
      lock_q    <= 1'b0;
      done_q    <= 1'b0;
      cooking_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      pre_q     <= pre_d;
      run_q     <= run_d;
      key_q     <= keypad;
      startn_q  <= startn;
      stopn_q   <= stopn;
      lock_q    <= lock_d;
      done_q    <= done_d;
      cooking_q <= cooking_d;
    end
  end

  assign min_bcd      = min_q;
  assign sec_tens_bcd = tens_q;
  assign sec_ones_bcd = ones_q;
  assign done         = done_q;
  assign cooking      = cooking_q;
  // Door gates the magnetron combinationally so it drops in the same cycle.
  assign mag_on       = (state_q == COOK) && door_closed;

endmodule

// File: tb/tb_cook_sequencer.sv
// Bench for cook_sequencer: behavioural model (time as minutes + two-digit seconds) feeds a scoreboard
// checked every cycle, plus directed checks against constants. QUICK_START_EN adds its directed case.
module tb_cook_sequencer;

  localparam int TD = 8;
  localparam int DB = 4;
  localparam int S_IDLE = 0, S_SET = 1, S_COOK = 2, S_PAUSE = 3;

  logic       clk = 1'b0;
  logic       clrn;
  logic [9:0] keypad;
  logic       startn, stopn, door_closed;
  logic [3:0] min_bcd, sec_tens_bcd, sec_ones_bcd;
  logic       mag_on, cooking, done;
  logic [14:0] dut_vec;

  always #5 clk = ~clk;

  cook_sequencer #(.TICK_DIV(TD), .DEBOUNCE(DB)) dut (
    .clk(clk), .clrn(clrn), .keypad(keypad), .startn(startn), .stopn(stopn),
    .door_closed(door_closed), .min_bcd(min_bcd), .sec_tens_bcd(sec_tens_bcd),
    .sec_ones_bcd(sec_ones_bcd), .mag_on(mag_on), .cooking(cooking), .done(done)
  );

  assign dut_vec = {min_bcd, sec_tens_bcd, sec_ones_bcd, mag_on, cooking, done};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: cook time held as minutes plus a 0..99 seconds field.
  int          m_state, m_min, m_sec, m_pre;
  bit          m_prev_start, m_prev_stop, m_armed, m_done;
  logic [9:0]  m_hist[$];
  logic [14:0] exp_q[$];

  function automatic void model_reset();
    m_state = S_IDLE; m_min = 0; m_sec = 0; m_pre = 0;
    m_prev_start = 1; m_prev_stop = 1; m_armed = 1; m_done = 0;
    m_hist.delete();
    repeat (DB) m_hist.push_back(10'd0);
  endfunction

  function automatic void enter_digit(input int k);
    int v;
    v = ((m_min * 100 + m_sec) * 10 + k) % 1000;
    m_min = v / 100;
    m_sec = v % 100;
  endfunction

  function automatic void model_step();
    bit sp, tp, acc, tick;
    int digit;
    sp = m_prev_start && !startn;
    tp = m_prev_stop && !stopn;
    m_prev_start = startn;
    m_prev_stop  = stopn;
    m_hist.push_back(keypad);
    void'(m_hist.pop_front());
    acc = m_armed && ($countones(keypad) == 1);
    foreach (m_hist[i]) if (m_hist[i] !== keypad) acc = 0;
    if (acc) m_armed = 0;
    if (keypad == 10'd0) m_armed = 1;
    digit = 0;
    for (int i = 0; i < 10; i++) if (keypad[i]) digit = i;
    m_done = 0;
    case (m_state)
      S_IDLE: begin
        if (tp) begin
          m_min = 0; m_sec = 0;
`ifdef QUICK_START_EN
        end else if (sp && door_closed) begin
          m_min = 0; m_sec = 30; m_pre = 0; m_state = S_COOK;
`endif
        end else if (acc) begin
          enter_digit(digit); m_state = S_SET;
        end
      end
      S_SET: begin
        if (tp) begin
          m_min = 0; m_sec = 0; m_state = S_IDLE;
        end else if (sp && door_closed && (m_min != 0 || m_sec != 0)) begin
          m_pre = 0; m_state = S_COOK;
        end else if (acc) begin
          enter_digit(digit);
        end
      end
      S_COOK: begin
        tick = (m_pre == TD - 1);
        if (tick && m_min == 0 && m_sec == 1) begin
          m_min = 0; m_sec = 0; m_pre = 0; m_done = 1; m_state = S_IDLE;
        end else if (!door_closed || tp) begin
          m_state = S_PAUSE;
        end else begin
          if (tick) begin
            m_pre = 0;
            if (m_sec > 0) m_sec--;
            else begin m_sec = 59; m_min--; end
          end else begin
            m_pre++;
          end
`ifdef QUICK_START_EN
          if (sp && m_min < 9) m_min++;
`endif
        end
      end
      default: begin
        if (tp) begin
          m_min = 0; m_sec = 0; m_state = S_IDLE;
        end else if (sp && door_closed) begin
          m_state = S_COOK;
        end
      end
    endcase
  endfunction

  function automatic logic [14:0] model_out();
    logic mag, ck;
    mag = (m_state == S_COOK) && door_closed;
    ck  = (m_state == S_COOK) || (m_state == S_PAUSE);
    return {4'(m_min), 4'(m_sec / 10), 4'(m_sec % 10), mag, ck, m_done};
  endfunction

  // One modelled clock: called with inputs settled, ends at the next falling edge.
  task automatic cyc();
    if (!clrn) model_reset();
    else       model_step();
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic hold(input int n);
    repeat (n) cyc();
  endtask

  task automatic press_key(input int d, input int n);
    keypad = 10'(1) << d;
    hold(n);
    keypad = 10'd0;
    hold(2);
  endtask

  task automatic press_start();
    startn = 1'b0; cyc(); cyc(); startn = 1'b1; cyc();
  endtask

  task automatic press_stop();
    stopn = 1'b0; cyc(); cyc(); stopn = 1'b1; cyc();
  endtask

  task automatic out_is(input string name, input logic [11:0] digits, input logic ck, input logic mag);
    check({name, "_digits"}, 32'({min_bcd, sec_tens_bcd, sec_ones_bcd}), 32'(digits));
    check({name, "_cooking"}, 32'(cooking), 32'(ck));
    check({name, "_mag_on"}, 32'(mag_on), 32'(mag));
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    bit seen = 0;
    while (!seen && n < bound) begin
      if (done === 1'b1) seen = 1;
      else begin cyc(); n++; end
    end
    check("done_seen", 32'(seen), 32'd1);
    cyc();
    check("done_one_cycle", 32'(done), 32'd0);
    out_is("after_done", 12'h000, 1'b0, 1'b0);
  endtask

  // Monitor: one expected snapshot per clock edge, compared just after the edge.
  initial begin
    logic [14:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("scoreboard", 32'(dut_vec), 32'(e));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, d, n;
    logic [9:0] kp;
    clrn = 1'b0; keypad = 10'd0; startn = 1'b1; stopn = 1'b1; door_closed = 1'b0;
    hold(3);
    out_is("reset", 12'h000, 1'b0, 1'b0);
    check("reset_done", 32'(done), 32'd0);
    clrn = 1'b1;
    hold(2);

    press_key(3, 6); press_key(5, 6); press_key(9, 6);
    out_is("keys_359", 12'h359, 1'b0, 1'b0);
    press_key(7, 50);
    out_is("key7_once", 12'h597, 1'b0, 1'b0);
    keypad = 10'b0000100100; hold(10); keypad = 10'd0; hold(2);
    out_is("two_keys_ignored", 12'h597, 1'b0, 1'b0);
    press_stop();
    out_is("set_stop", 12'h000, 1'b0, 1'b0);

    press_key(2, 5);
    press_start();
    out_is("start_door_open", 12'h002, 1'b0, 1'b0);
    door_closed = 1'b1; cyc();
    press_start();
    out_is("cook_start", 12'h002, 1'b1, 1'b1);
    hold(TD - 2);
    out_is("first_tick", 12'h001, 1'b1, 1'b1);
    wait_done(3 * TD);

    press_key(1, 5); press_key(0, 5); press_key(0, 5);
    press_start(); hold(TD - 2);
    out_is("borrow_min", 12'h059, 1'b1, 1'b1);
    press_stop(); press_stop();
    press_key(9, 5); press_key(9, 5);
    press_start(); hold(TD - 2);
    out_is("tens_over_5", 12'h098, 1'b1, 1'b1);
    press_stop(); press_stop();
    press_key(9, 5); press_key(0, 5);
    press_start(); hold(TD - 2);
    out_is("borrow_tens", 12'h089, 1'b1, 1'b1);
    press_stop(); press_stop();

    press_key(5, 5);
    press_start(); hold(2);
    door_closed = 1'b0;
    #1 check("mag_door_cut", 32'(mag_on), 32'd0);
    cyc(); hold(4);
    out_is("paused", 12'h005, 1'b1, 1'b0);
    door_closed = 1'b1; cyc();
    press_start(); hold(1);
    out_is("resume_pre", 12'h005, 1'b1, 1'b1);
    hold(1);
    out_is("resume_tick", 12'h004, 1'b1, 1'b1);
    press_stop(); press_stop();
    out_is("pause_stop", 12'h000, 1'b0, 1'b0);

    press_key(9, 5);
    press_start(); hold(2);
    startn = 1'b0; stopn = 1'b0; cyc();
    startn = 1'b1; stopn = 1'b1; cyc();
    out_is("start_stop_same", 12'h009, 1'b1, 1'b0);
    press_stop();
    out_is("same_then_stop", 12'h000, 1'b0, 1'b0);

`ifdef QUICK_START_EN
    press_start();
    out_is("quick_start", 12'h030, 1'b1, 1'b1);
    press_stop(); press_stop();
`endif

    press_key(8, 5);
    press_start(); hold(3);
    #2 clrn = 1'b0;
    #1 out_is("async_reset", 12'h000, 1'b0, 1'b0);
    check("async_reset_done", 32'(done), 32'd0);
    cyc(); hold(1);
    clrn = 1'b1;
    hold(2);

    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        d = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(0, 9);
        keypad = 10'(1) << d;
        hold($urandom_range(1, 7));
        keypad = 10'd0;
        hold($urandom_range(0, 3));
      end else if (r < 38) begin
        kp = 10'($urandom);
        if ($countones(kp) == 1) kp = 10'd0;
        keypad = kp;
        hold($urandom_range(1, 5));
        keypad = 10'd0;
      end else if (r < 55) begin
        press_start();
      end else if (r < 65) begin
        press_stop();
      end else if (r < 75) begin
        door_closed = ~door_closed;
        hold($urandom_range(1, 4));
      end else if (r < 80) begin
        startn = 1'b0; stopn = 1'b0; cyc();
        startn = 1'b1; stopn = 1'b1; cyc();
      end else if (r < 95) begin
        n = $urandom_range(1, 40);
        hold(n);
      end else begin
        n = $urandom_range(100, 400);
        hold(n);
      end
    end
    keypad = 10'd0; startn = 1'b1; stopn = 1'b1;
    hold(3);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
